// File: rtl/pipe_stage_pkg.sv
// Shared widths and helpers for the elastic pipeline stage register.
package pipe_stage_pkg;

  localparam int STATS_W = 32;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Saturating increment for the occupancy statistics counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1'b1);
  endfunction

endpackage

// File: rtl/pipe_stage_ptr.sv
// Modulo-DEPTH pointer register; wraps from DEPTH-1 to 0 for any DEPTH >= 1.
module pipe_stage_ptr
  import pipe_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_nxt_s;

  // Next-pointer selection with explicit wrap at the last entry.
  always_comb begin
    ptr_nxt_s = ptr;
    if (clr) begin
      ptr_nxt_s = {PTR_W{1'b0}};
    end else if (inc) begin
      if (ptr == PTR_W'(DEPTH - 1)) begin
        ptr_nxt_s = {PTR_W{1'b0}};
      end else begin
        ptr_nxt_s = ptr + PTR_W'(1'b1);
      end
    end else begin
      ptr_nxt_s = ptr;
    end
  end

  // Pointer state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= {PTR_W{1'b0}};
    end else begin
      ptr <= ptr_nxt_s;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic DEPTH-entry pipeline stage with valid/ready handshake and flush.
// Optional stall/bubble statistics are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_elastic
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [STATS_W-1:0] stall_cnt,
  output logic [STATS_W-1:0] bubble_cnt
`endif
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_s;
  logic [PTR_W-1:0]  rd_ptr_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  // in_ready depends only on count_r, so out_ready never reaches it combinationally.
  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign push_s    = in_valid & ~full_s & ~flush;
  assign pop_s     = ~empty_s & out_ready & ~flush;
  assign in_ready  = ~full_s;
  assign out_valid = ~empty_s;
  assign count     = count_r;
  assign out_data  = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_s];

  pipe_stage_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .CLK (CLK),
    .RST (RST),
    .clr (flush),
    .inc (push_s),
    .ptr (wr_ptr_s)
  );

  pipe_stage_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .CLK (CLK),
    .RST (RST),
    .clr (flush),
    .inc (pop_s),
    .ptr (rd_ptr_s)
  );

  // Occupancy next-state: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Occupancy register; reset outranks flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  // Payload storage is never cleared; out_data is masked while empty.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_s] <= in_data;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [STATS_W-1:0] stall_r;
  logic [STATS_W-1:0] bubble_r;

  // Saturating stall/bubble counters; cleared by reset only, not by flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_r  <= {STATS_W{1'b0}};
      bubble_r <= {STATS_W{1'b0}};
    end else begin
      if (out_valid & ~out_ready) begin
        stall_r <= sat_inc(stall_r);
      end
      if (~out_valid & out_ready) begin
        bubble_r <= sat_inc(bubble_r);
      end
    end
  end

  assign stall_cnt  = stall_r;
  assign bubble_cnt = bubble_r;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic at DEPTH 3, 2 and 1 (stats checks under PIPE_STAGE_STATS_EN).
module tb_pipe_stage_elastic;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic        v3, r3, ov3, ordy3, fl3;
  logic [15:0] d3, od3;
  logic [1:0]  c3;
  logic        v2, r2, ov2, ordy2, fl2;
  logic [15:0] d2, od2;
  logic [1:0]  c2;
  logic        v1, r1, ov1, ordy1, fl1;
  logic [15:0] d1, od1;
  logic [0:0]  c1;
  logic [31:0] st3, bu3, st2, bu2, st1, bu1;

  int vectors = 0;
  int miscompares = 0;

  pipe_stage_elastic #(.DATA_W(16), .DEPTH(3)) dut3 (
    .CLK(CLK), .RST(RST), .in_valid(v3), .in_ready(r3), .in_data(d3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .flush(fl3), .count(c3)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(st3), .bubble_cnt(bu3)
`endif
  );

  pipe_stage_elastic #(.DATA_W(16), .DEPTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .in_valid(v2), .in_ready(r2), .in_data(d2),
    .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .flush(fl2), .count(c2)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(st2), .bubble_cnt(bu2)
`endif
  );

  pipe_stage_elastic #(.DATA_W(16), .DEPTH(1)) dut1 (
    .CLK(CLK), .RST(RST), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .flush(fl1), .count(c1)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(st1), .bubble_cnt(bu1)
`endif
  );

`ifndef PIPE_STAGE_STATS_EN
  initial begin
    st3 = 32'd0; bu3 = 32'd0; st2 = 32'd0; bu2 = 32'd0; st1 = 32'd0; bu1 = 32'd0;
  end
`endif

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_q [3];

  initial begin
    RST = 1'b1;
    v3 = 1'b1; d3 = 16'hAAAA; ordy3 = 1'b0; fl3 = 1'b0;
    v2 = 1'b1; d2 = 16'hBBBB; ordy2 = 1'b0; fl2 = 1'b0;
    v1 = 1'b1; d1 = 16'hCCCC; ordy1 = 1'b0; fl1 = 1'b0;
    tick();
    tick();
    RST = 1'b0; v3 = 1'b0; v2 = 1'b0; v1 = 1'b0;

    // Reset state
    check("rst_count3", 32'(c3), 32'd0);
    check("rst_ovalid3", 32'(ov3), 32'd0);
    check("rst_iready3", 32'(r3), 32'd1);
    check("rst_odata3", 32'(od3), 32'd0);
    check("rst_count2", 32'(c2), 32'd0);
    check("rst_iready1", 32'(r1), 32'd1);
    check("rst_odata1", 32'(od1), 32'd0);

`ifdef PIPE_STAGE_STATS_EN
    // Stats on DEPTH=1: 4 stall cycles, one pop, 3 bubble cycles, then a flush
    check("rst_stall1", st1, 32'd0);
    check("rst_bubble1", bu1, 32'd0);
    v1 = 1'b1; d1 = 16'h0011; tick();
    v1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    ordy1 = 1'b1; tick();
    for (int i = 0; i < 3; i++) tick();
    ordy1 = 1'b0;
    check("stall_cnt", st1, 32'd4);
    check("bubble_cnt", bu1, 32'd3);
    v1 = 1'b1; d1 = 16'h0022; tick();
    v1 = 1'b0; fl1 = 1'b1; ordy1 = 1'b1; tick();
    fl1 = 1'b0; ordy1 = 1'b0;
    check("flush_count1", 32'(c1), 32'd0);
    check("flush_stall", st1, 32'd4);
    check("flush_bubble", bu1, 32'd3);
`endif

    // Fill DEPTH=3 with A1..A3 while downstream stalls
    v3 = 1'b1;
    d3 = 16'h00A1; tick();
    d3 = 16'h00A2; tick();
    d3 = 16'h00A3; tick();
    d3 = 16'h00A4;
    check("full_count3", 32'(c3), 32'd3);
    check("full_iready3", 32'(r3), 32'd0);
    check("full_head3", 32'(od3), 32'h00A1);
    ordy3 = 1'b1; tick();
    check("pop1_count3", 32'(c3), 32'd2);
    check("pop1_head3", 32'(od3), 32'h00A2);
    check("pop1_iready3", 32'(r3), 32'd1);
    ordy3 = 1'b0; tick();
    check("wrap_count3", 32'(c3), 32'd3);
    v3 = 1'b0; ordy3 = 1'b1;
    exp_q[0] = 16'h00A2; exp_q[1] = 16'h00A3; exp_q[2] = 16'h00A4;
    for (int i = 0; i < 3; i++) begin
      check("drain_order3", 32'(od3), 32'(exp_q[i]));
      tick();
    end
    ordy3 = 1'b0;
    check("drain_count3", 32'(c3), 32'd0);
    check("drain_ovalid3", 32'(ov3), 32'd0);
    check("drain_odata3", 32'(od3), 32'd0);

    // Streaming on DEPTH=2 at one payload per cycle
    ordy2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v2 = 1'b1; d2 = 16'h0010 + 16'(i);
      tick();
      check("stream_ovalid2", 32'(ov2), 32'd1);
      check("stream_odata2", 32'(od2), 32'h0010 + 32'(i));
      check("stream_count2", 32'(c2), 32'd1);
    end
    v2 = 1'b0; tick();
    ordy2 = 1'b0;
    check("stream_end_ovalid2", 32'(ov2), 32'd0);

    // Flush with simultaneous push and pop at count=2 on DEPTH=3
    v3 = 1'b1;
    d3 = 16'h0021; tick();
    d3 = 16'h0022; tick();
    check("preflush_count3", 32'(c3), 32'd2);
    fl3 = 1'b1; d3 = 16'hDEAD; ordy3 = 1'b1; tick();
    fl3 = 1'b0; v3 = 1'b0;
    check("flush_count3", 32'(c3), 32'd0);
    check("flush_ovalid3", 32'(ov3), 32'd0);
    check("flush_odata3", 32'(od3), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_dead3", 32'(ov3), 32'd0);
    end
    ordy3 = 1'b0; v3 = 1'b1; d3 = 16'h0031; tick();
    v3 = 1'b0;
    check("postflush_head3", 32'(od3), 32'h0031);
    check("postflush_count3", 32'(c3), 32'd1);

    // DEPTH=1 backpressure: entry held for 5 cycles, then exactly one pop
    v1 = 1'b1; d1 = 16'h0055; tick();
    d1 = 16'h0066;
    for (int i = 0; i < 5; i++) begin
      check("bp_iready1", 32'(r1), 32'd0);
      check("bp_odata1", 32'(od1), 32'h0055);
      tick();
    end
    v1 = 1'b0; ordy1 = 1'b1;
    check("bp_head1", 32'(od1), 32'h0055);
    tick();
    ordy1 = 1'b0;
    check("bp_pop_count1", 32'(c1), 32'd0);
    check("bp_pop_ovalid1", 32'(ov1), 32'd0);
    tick();
    check("bp_idle_count1", 32'(c1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
